// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping, and reports the winner both one-hot and as an index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: accepts one byte from NUM_REQ sources
// and serialises it as start / DATA_BITS LSB-first / STOP_BITS stop, paced by i_baud_tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_baud_tick,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_tx,
  output logic                         o_busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_BITS);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [IW-1:0]        ptr;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_index;
  logic                 arb_found;
  logic [DATA_BITS-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_index),
    .found (arb_found)
  );

  // Ready is the arbiter grant gated by IDLE, so the byte is taken in the same cycle.
  assign o_req_ready = (state == IDLE) ? arb_grant : '0;
  assign sel_data    = i_req_data[int'(arb_index)*DATA_BITS +: DATA_BITS];

  // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_tx       <= UART_IDLE_LEVEL;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_tx <= UART_IDLE_LEVEL;
          if (arb_found) begin
            shift      <= sel_data;
            o_grant_id <= arb_index;
            ptr        <= arb_index;
            o_busy     <= 1'b1;
            state      <= SYNC;
          end
        end
        // SYNC waits for a tick so the start bit begins on a bit boundary.
        SYNC: begin
          if (i_baud_tick) begin
            o_tx  <= UART_START_LEVEL;
            state <= START;
          end
        end
        START: begin
          if (i_baud_tick) begin
            o_tx    <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (i_baud_tick) begin
            if (bit_cnt == CW'(DATA_BITS - 1)) begin
              o_tx     <= UART_IDLE_LEVEL;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              shift   <= shift >> 1;
              o_tx    <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_baud_tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
